set_sel_sweeper: RTL and testbench
==================================

Name: set_sel_sweeper

Overview:
- Registered, parametrised index-to-one-hot set-select generator for the set-associative cache.
- Two modes: single decode (one beat) or sweep (one beat per index from start to end, wrapping), used for flush/invalidate walks.
- Sits between the cache controller (request side) and the tag/data array set enables (select side).
- Valid/ready handshake on both sides; output is fully registered.

Parameters:
- N_SETS, 32, number of sets / one-hot width; any value >= 2, need not be a power of two.
- IDX_W, $clog2(N_SETS), index width; derived localparam, not overridable.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when high with req_valid.
- req_mode  in  1  0 = single, 1 = sweep.
- req_idx  in  IDX_W  single index, or sweep start index.
- req_end  in  IDX_W  sweep end index, inclusive; ignored in single mode.
- sel_valid  out  1  output beat present.
- sel_ready  in  1  downstream accepts beat.
- sel_onehot  out  N_SETS  one-hot set select; bit k high for index k.
- sel_idx  out  IDX_W  binary index of the current beat.
- sel_last  out  1  final beat of the transaction.
- busy  out  1  state == SWEEP or sel_valid.
- err  out  1  one-cycle pulse: request rejected as out of range.

Behaviour:
- Reset (async assert, sync-safe release) values: sel_valid=0, sel_onehot=0, sel_idx=0, sel_last=0, err=0, state=IDLE, counter=0.
- FSM states: IDLE, SWEEP.
- req_ready = (state==IDLE) && (!sel_valid || sel_ready). Combinational; no dependence on req_valid.
- Out-of-range check: applies when req_idx >= N_SETS, or req_end >= N_SETS in sweep mode.
  - Request is consumed, err pulses high the next cycle, no beat is produced, state stays IDLE.
- Single mode accept: next cycle sel_valid=1, sel_onehot=1<<req_idx, sel_idx=req_idx, sel_last=1. Latency 1 cycle.
- Sweep mode accept: first beat as single mode, with sel_last=(req_idx==req_end).
  - If not last: state becomes SWEEP, counter=req_idx, end register latched.
- In SWEEP, on each cycle with sel_valid && sel_ready:
  - Next index = counter+1, wrapping from N_SETS-1 to 0 (modulo N_SETS, not 2^IDX_W).
  - Load the next beat; set sel_last when next index == end, and return to IDLE.
- Back-to-back: sustained one beat per cycle while sel_ready is high.
- A new request may be accepted in the same cycle the last beat is taken; no bubble.
- sel_ready low: beat held stable (onehot, idx, last unchanged); counter frozen.
- Wrap: start=30, end=1, N_SETS=32 gives beats 30, 31, 0, 1.
  - end == start-1 (mod N_SETS) gives a full N_SETS-beat sweep.
  - end == start gives one beat.
- sel_onehot is always exactly one-hot when sel_valid=1, and all-zero when sel_valid=0.
- Reset asserted mid-sweep: immediate return to reset values; the transaction is lost and not resumed.

Optional Feature:
- Macro: SET_SEL_SWEEPER_ABORT_EN.
- Defined: adds input abort (1 bit) and output aborted (1 bit).
  - abort high while busy: next cycle sel_valid=0, state=IDLE, aborted pulses high for one cycle.
  - A beat held in the output register is discarded.
  - abort while idle and sel_valid=0 has no effect and no pulse.
  - abort has priority over sel_ready acceptance and over a new req accept in the same cycle; req_ready is forced low while abort is high.
- Undefined: both ports absent; a sweep always runs to completion.

Decomposition:
- Shared package cache_pkg holds:
  - the mode enum (SEL_SINGLE=0, SEL_SWEEP=1);
  - the FSM state typedef;
  - default N_SETS constant 32.
- One sub-module: idx_onehot, a combinational parametrised N_SETS-wide one-hot decoder (zero output for index >= N_SETS). Instantiated once, feeding the output register.
- Wrap-increment and range compare stay in the top module.

Test Plan:
- Single: req_idx=5, mode=0, sel_ready=1 -> one cycle later sel_onehot=32'h00000020, sel_idx=5, sel_last=1; busy drops after acceptance.
- Sweep with wrap: start=30, end=1, sel_ready=1 -> beats 0x40000000, 0x80000000, 0x00000001, 0x00000002 on consecutive cycles; sel_last only on the 4th.
- Backpressure: sweep 0..3 with sel_ready toggling 1,0,0,1,... -> each beat held stable while ready is low; no index skipped or duplicated; req_ready low until the last beat is taken.
- Range, N_SETS=20: req_idx=25 -> err pulse one cycle, no sel_valid. Sweep start=19, end=0 -> beats 19, 0 (modulo 20).
- Full sweep: start=7, end=6 -> exactly 32 beats covering every bit once; a new single request is accepted in the cycle the last beat is taken, with its beat the following cycle.
- Reset mid-sweep: rst_n low at beat 3 of 0..31 -> same-cycle clear of sel_valid/sel_onehot. With SET_SEL_SWEEPER_ABORT_EN: abort at beat 3 -> sel_valid=0 and aborted=1 next cycle, state IDLE.

Source files
------------

// File: rtl/cache_pkg.sv
// ----------------------------------------------------------------------------
// cache_pkg
// Shared types and constants for the set-associative cache datapath.
//
// Contents:
//   DEFAULT_N_SETS  default number of cache sets (one-hot select width)
//   sel_mode_e      request mode of the set-select sweeper (single / sweep)
//   sweep_state_e   FSM state of the set-select sweeper
//   idx_in_range    helper: index is a legal set number for a given set count
// ----------------------------------------------------------------------------
package cache_pkg;

    localparam int DEFAULT_N_SETS = 32;

    typedef enum logic {
        SEL_SINGLE = 1'b0,
        SEL_SWEEP  = 1'b1
    } sel_mode_e;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SWEEP = 1'b1
    } sweep_state_e;

    // Done on 32-bit values so the compare stays meaningful when the set
    // count is not a power of two and the index field has spare codes.
    function automatic logic idx_in_range(input logic [31:0] idx,
                                          input logic [31:0] n_sets);
        return idx < n_sets;
    endfunction

endpackage

// File: rtl/idx_onehot.sv
// ----------------------------------------------------------------------------
// idx_onehot
// Combinational binary-index to one-hot decoder, N_SETS bits wide.
// Index codes at or above N_SETS (possible when N_SETS is not a power of two)
// decode to all zeros.
//
// Parameters:
//   N_SETS  output width / number of sets (>= 2)
//   IDX_W   derived index width, $clog2(N_SETS)
// Ports:
//   idx     in   IDX_W   binary index
//   onehot  out  N_SETS  bit k high when idx == k
// ----------------------------------------------------------------------------
module idx_onehot
    import cache_pkg::*;
#(
    parameter  int N_SETS = DEFAULT_N_SETS,
    localparam int IDX_W  = $clog2(N_SETS)
) (
    input  logic [IDX_W-1:0]  idx,
    output logic [N_SETS-1:0] onehot
);

    always_comb begin
        onehot = '0;
        for (int k = 0; k < N_SETS; k++) begin
            if (32'(idx) == 32'(k)) begin
                onehot[k] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/set_sel_sweeper.sv
// ----------------------------------------------------------------------------
// set_sel_sweeper
// Registered index-to-one-hot set-select generator for the set-associative
// cache. A request either decodes one index (single mode) or walks every
// index from a start to an inclusive end, wrapping modulo N_SETS (sweep
// mode), producing one output beat per index. Used by the cache controller
// for flush / invalidate walks over the tag and data array set enables.
//
// Optional feature (macro SET_SEL_SWEEPER_ABORT_EN):
//   adds an abort input that cancels the running transaction, and an
//   aborted output that pulses one cycle when that happens.
//
// Parameters:
//   N_SETS      number of sets / one-hot width (>= 2, any value)
//   IDX_W       derived index width, $clog2(N_SETS)
// Ports:
//   clk         in   1       clock, rising edge
//   rst_n       in   1       asynchronous active-low reset
//   req_valid   in   1       request present
//   req_ready   out  1       request accepted when high with req_valid
//   req_mode    in   1       0 = single, 1 = sweep
//   req_idx     in   IDX_W   single index or sweep start index
//   req_end     in   IDX_W   sweep end index (inclusive), unused in single
//   sel_valid   out  1       output beat present
//   sel_ready   in   1       downstream accepts the beat
//   sel_onehot  out  N_SETS  one-hot set select of the current beat
//   sel_idx     out  IDX_W   binary index of the current beat
//   sel_last    out  1       final beat of the transaction
//   busy        out  1       sweep in progress or beat pending
//   err         out  1       one-cycle pulse: request rejected, out of range
//   abort       in   1       (ABORT_EN only) cancel current transaction
//   aborted     out  1       (ABORT_EN only) one-cycle pulse after a cancel
// ----------------------------------------------------------------------------
module set_sel_sweeper
    import cache_pkg::*;
#(
    parameter  int N_SETS = DEFAULT_N_SETS,
    localparam int IDX_W  = $clog2(N_SETS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_mode,
    input  logic [IDX_W-1:0]  req_idx,
    input  logic [IDX_W-1:0]  req_end,
    output logic              sel_valid,
    input  logic              sel_ready,
    output logic [N_SETS-1:0] sel_onehot,
    output logic [IDX_W-1:0]  sel_idx,
    output logic              sel_last,
    output logic              busy,
    output logic              err
`ifdef SET_SEL_SWEEPER_ABORT_EN
    ,
    input  logic              abort,
    output logic              aborted
`endif
);

    sweep_state_e     state;
    logic [IDX_W-1:0] counter;
    logic [IDX_W-1:0] end_idx;

    logic             mode_sweep;
    logic             accept;
    logic             beat_taken;
    logic             range_bad;
    logic             abort_now;
    logic             abort_block;
    logic [IDX_W-1:0] next_idx;
    logic [IDX_W-1:0] load_idx;
    logic [N_SETS-1:0] load_onehot;

`ifdef SET_SEL_SWEEPER_ABORT_EN
    // An abort only acts when there is something to cancel, but it always
    // blocks new requests so it wins over a same-cycle accept.
    assign abort_now   = abort && busy;
    assign abort_block = abort;
`else
    assign abort_now   = 1'b0;
    assign abort_block = 1'b0;
`endif

    assign mode_sweep = (sel_mode_e'(req_mode) == SEL_SWEEP);
    assign busy       = (state == ST_SWEEP) || sel_valid;
    assign req_ready  = (state == ST_IDLE) && (!sel_valid || sel_ready) && !abort_block;
    assign accept     = req_valid && req_ready;
    assign beat_taken = sel_valid && sel_ready;

    // The end index only matters in sweep mode; a single request with a
    // junk end field must not be rejected.
    assign range_bad = !idx_in_range(32'(req_idx), 32'(N_SETS)) ||
                       (mode_sweep && !idx_in_range(32'(req_end), 32'(N_SETS)));

    // Wrap at N_SETS-1 rather than letting the counter roll over at
    // 2^IDX_W, so non-power-of-two set counts never visit illegal indices.
    assign next_idx = (counter == IDX_W'(N_SETS - 1)) ? '0 : counter + 1'b1;

    // In IDLE the next beat can only come from a new request; in SWEEP it
    // is always the successor of the current index.
    assign load_idx = (state == ST_IDLE) ? req_idx : next_idx;

    idx_onehot #(
        .N_SETS (N_SETS)
    ) u_decode (
        .idx    (load_idx),
        .onehot (load_onehot)
    );

    // Control FSM and output register. A beat is replaced only when the
    // current one is taken, which keeps it stable under backpressure and
    // lets a new request land in the same cycle the last beat leaves.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            counter    <= '0;
            end_idx    <= '0;
            sel_valid  <= 1'b0;
            sel_onehot <= '0;
            sel_idx    <= '0;
            sel_last   <= 1'b0;
            err        <= 1'b0;
`ifdef SET_SEL_SWEEPER_ABORT_EN
            aborted    <= 1'b0;
`endif
        end else begin
            err <= 1'b0;
`ifdef SET_SEL_SWEEPER_ABORT_EN
            aborted <= 1'b0;
`endif
            if (abort_now) begin
                state      <= ST_IDLE;
                sel_valid  <= 1'b0;
                sel_onehot <= '0;
                sel_last   <= 1'b0;
`ifdef SET_SEL_SWEEPER_ABORT_EN
                aborted    <= 1'b1;
`endif
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (accept && !range_bad) begin
                            sel_valid  <= 1'b1;
                            sel_onehot <= load_onehot;
                            sel_idx    <= req_idx;
                            sel_last   <= !mode_sweep || (req_idx == req_end);
                            if (mode_sweep && (req_idx != req_end)) begin
                                state   <= ST_SWEEP;
                                counter <= req_idx;
                                end_idx <= req_end;
                            end
                        end else begin
                            if (accept) begin
                                err <= 1'b1;
                            end
                            if (beat_taken) begin
                                sel_valid  <= 1'b0;
                                sel_onehot <= '0;
                                sel_last   <= 1'b0;
                            end
                        end
                    end
                    ST_SWEEP: begin
                        if (beat_taken) begin
                            sel_onehot <= load_onehot;
                            sel_idx    <= next_idx;
                            sel_last   <= (next_idx == end_idx);
                            counter    <= next_idx;
                            if (next_idx == end_idx) begin
                                state <= ST_IDLE;
                            end
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_set_sel_sweeper.sv
// ----------------------------------------------------------------------------
// tb_set_sel_sweeper
// Self-checking bench for set_sel_sweeper. Two instances: a default 32-set
// one and a 20-set one for the non-power-of-two range and wrap behaviour.
// Expected beats come from a list-building reference model of the walk.
// ----------------------------------------------------------------------------
module tb_set_sel_sweeper;

    logic        clk;
    logic        rst_n;
    logic        req_valid_a;
    logic        req_valid_b;
    logic        req_mode;
    logic [4:0]  req_idx;
    logic [4:0]  req_end;
    logic        sel_ready;

    logic        req_ready_a, sel_valid_a, sel_last_a, busy_a, err_a;
    logic [31:0] onehot_a;
    logic [4:0]  idx_a;
    logic        req_ready_b, sel_valid_b, sel_last_b, busy_b, err_b;
    logic [19:0] onehot_b;
    logic [4:0]  idx_b;
`ifdef SET_SEL_SWEEPER_ABORT_EN
    logic        abort;
    logic        aborted_a, aborted_b;
`endif

    int errors = 0;
    int checks = 0;
    int which  = 0;
    int exp_q[$];

    logic        o_req_ready, o_valid, o_last, o_busy, o_err;
    logic [31:0] o_onehot;
    logic [4:0]  o_idx;

    set_sel_sweeper #(.N_SETS(32)) dut_a (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid_a),
        .req_ready  (req_ready_a),
        .req_mode   (req_mode),
        .req_idx    (req_idx),
        .req_end    (req_end),
        .sel_valid  (sel_valid_a),
        .sel_ready  (sel_ready),
        .sel_onehot (onehot_a),
        .sel_idx    (idx_a),
        .sel_last   (sel_last_a),
        .busy       (busy_a),
        .err        (err_a)
`ifdef SET_SEL_SWEEPER_ABORT_EN
        ,
        .abort      (abort),
        .aborted    (aborted_a)
`endif
    );

    set_sel_sweeper #(.N_SETS(20)) dut_b (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid_b),
        .req_ready  (req_ready_b),
        .req_mode   (req_mode),
        .req_idx    (req_idx),
        .req_end    (req_end),
        .sel_valid  (sel_valid_b),
        .sel_ready  (sel_ready),
        .sel_onehot (onehot_b),
        .sel_idx    (idx_b),
        .sel_last   (sel_last_b),
        .busy       (busy_b),
        .err        (err_b)
`ifdef SET_SEL_SWEEPER_ABORT_EN
        ,
        .abort      (abort),
        .aborted    (aborted_b)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // View of whichever instance the current test targets.
    always_comb begin
        if (which == 1) begin
            o_req_ready = req_ready_b;
            o_valid     = sel_valid_b;
            o_onehot    = {12'b0, onehot_b};
            o_idx       = idx_b;
            o_last      = sel_last_b;
            o_busy      = busy_b;
            o_err       = err_b;
        end else begin
            o_req_ready = req_ready_a;
            o_valid     = sel_valid_a;
            o_onehot    = onehot_a;
            o_idx       = idx_a;
            o_last      = sel_last_a;
            o_busy      = busy_a;
            o_err       = err_a;
        end
    end

    // Reference model: the list of indices a request should produce, or 1
    // when the request must be rejected.
    function automatic bit build_model(input int n, input int mode, input int start, input int stop);
        int i;
        exp_q.delete();
        if (start >= n || (mode == 1 && stop >= n)) return 1'b1;
        if (mode == 0) begin
            exp_q.push_back(start);
            return 1'b0;
        end
        i = start;
        for (int s = 0; s < n; s++) begin
            exp_q.push_back(i);
            if (i == stop) break;
            i = (i + 1) % n;
        end
        return 1'b0;
    endfunction

    task automatic drive_req(input logic v);
        if (which == 1) req_valid_b = v;
        else            req_valid_a = v;
    endtask

    // Issue one request to the targeted instance and follow it to the end.
    // rmode: 0 ready always high, 1 ready pattern 1,0,0,..., 2 random ready.
    // chain >= 0: a single request for that index rides on the last beat.
    task automatic run_txn(input int mode, input int start, input int stop,
                           input int rmode, input int chain);
        int  n, k, cyc, limit, ev, last_k;
        bit  bad;
        logic rdy, chained;
        n = (which == 1) ? 20 : 32;
        bad = build_model(n, mode, start, stop);
        req_mode  = mode[0];
        req_idx   = start[4:0];
        req_end   = stop[4:0];
        sel_ready = 1'b1;
        drive_req(1'b1);
        #1;
        checks++;
        if (o_req_ready !== 1'b1)
            $display("[TB] FAIL req_ready_idle dut=%0d got=%b want=1", which, o_req_ready);
        @(posedge clk); #1;
        drive_req(1'b0);
        if (bad) begin
            checks++;
            if (o_err !== 1'b1 || o_valid !== 1'b0) begin
                errors++;
                $display("[TB] FAIL range_err dut=%0d start=%0d end=%0d got err=%b valid=%b want err=1 valid=0",
                         which, start, stop, o_err, o_valid);
            end
            @(posedge clk); #1;
            checks++;
            if (o_err !== 1'b0 || o_valid !== 1'b0 || o_busy !== 1'b0) begin
                errors++;
                $display("[TB] FAIL range_after dut=%0d got err=%b valid=%b busy=%b want 0 0 0",
                         which, o_err, o_valid, o_busy);
            end
            return;
        end
        k = 0;
        cyc = 0;
        chained = 1'b0;
        last_k = exp_q.size() - 1;
        limit = exp_q.size() * 8 + 20;
        while (k < exp_q.size() && cyc < limit) begin
            ev = exp_q[k];
            checks++;
            if (o_valid !== 1'b1 || o_idx !== ev[4:0] || o_onehot !== (32'd1 << ev) ||
                o_last !== (k == last_k) || o_busy !== 1'b1 || o_err !== 1'b0) begin
                errors++;
                $display("[TB] FAIL beat dut=%0d k=%0d got valid=%b idx=%0d onehot=%h last=%b busy=%b err=%b want idx=%0d onehot=%h last=%b",
                         which, k, o_valid, o_idx, o_onehot, o_last, o_busy, o_err,
                         ev, 32'd1 << ev, (k == last_k));
            end
            case (rmode)
                0:       rdy = 1'b1;
                1:       rdy = (cyc % 3 == 0);
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            sel_ready = rdy;
            if (k == last_k && rdy && chain >= 0) begin
                req_mode = 1'b0;
                req_idx  = chain[4:0];
                drive_req(1'b1);
                chained = 1'b1;
            end
            #1;
            checks++;
            if (o_req_ready !== ((k == last_k) ? rdy : 1'b0)) begin
                errors++;
                $display("[TB] FAIL req_ready_busy dut=%0d k=%0d got=%b want=%b",
                         which, k, o_req_ready, ((k == last_k) ? rdy : 1'b0));
            end
            @(posedge clk); #1;
            drive_req(1'b0);
            if (rdy) k++;
            cyc++;
        end
        if (k < exp_q.size()) begin
            errors++;
            $display("[TB] FAIL txn_timeout dut=%0d beats=%0d of %0d", which, k, exp_q.size());
        end
        sel_ready = 1'b1;
        if (chained) begin
            checks++;
            if (o_valid !== 1'b1 || o_idx !== chain[4:0] || o_onehot !== (32'd1 << chain) || o_last !== 1'b1) begin
                errors++;
                $display("[TB] FAIL chained_beat dut=%0d got valid=%b idx=%0d onehot=%h last=%b want idx=%0d last=1",
                         which, o_valid, o_idx, o_onehot, o_last, chain);
            end
            @(posedge clk); #1;
        end
        checks++;
        if (o_valid !== 1'b0 || o_onehot !== 32'd0 || o_busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL drained dut=%0d got valid=%b onehot=%h busy=%b want 0 0 0",
                     which, o_valid, o_onehot, o_busy);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (sel_valid_a !== 1'b0 || onehot_a !== 32'd0 || idx_a !== 5'd0 || sel_last_a !== 1'b0 ||
            err_a !== 1'b0 || busy_a !== 1'b0 || sel_valid_b !== 1'b0 || onehot_b !== 20'd0) begin
            errors++;
            $display("[TB] FAIL reset_values got valid=%b onehot=%h idx=%0d last=%b err=%b busy=%b validb=%b want all 0",
                     sel_valid_a, onehot_a, idx_a, sel_last_a, err_a, busy_a, sel_valid_b);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (req_ready_a !== 1'b1 || sel_valid_a !== 1'b0) begin
            errors++;
            $display("[TB] FAIL post_reset got req_ready=%b valid=%b want 1 0", req_ready_a, sel_valid_a);
        end
    endtask

    task automatic test_single;
        which = 0;
        req_mode = 1'b0; req_idx = 5'd5; req_end = 5'd17; sel_ready = 1'b1;
        req_valid_a = 1'b1;
        @(posedge clk); #1;
        req_valid_a = 1'b0;
        checks++;
        if (sel_valid_a !== 1'b1 || onehot_a !== 32'h00000020 || idx_a !== 5'd5 || sel_last_a !== 1'b1) begin
            errors++;
            $display("[TB] FAIL single_beat got valid=%b onehot=%h idx=%0d last=%b want 1 00000020 5 1",
                     sel_valid_a, onehot_a, idx_a, sel_last_a);
        end
        @(posedge clk); #1;
        checks++;
        if (sel_valid_a !== 1'b0 || busy_a !== 1'b0) begin
            errors++;
            $display("[TB] FAIL single_done got valid=%b busy=%b want 0 0", sel_valid_a, busy_a);
        end
    endtask

    task automatic test_sweep_wrap;
        which = 0;
        run_txn(1, 30, 1, 0, -1);
        run_txn(1, 9, 9, 0, -1);
    endtask

    task automatic test_backpressure;
        which = 0;
        run_txn(1, 0, 3, 1, -1);
        which = 1;
        run_txn(1, 17, 2, 1, -1);
    endtask

    task automatic test_range;
        which = 1;
        run_txn(0, 25, 0, 0, -1);
        run_txn(1, 3, 22, 0, -1);
        run_txn(1, 19, 0, 0, -1);
        run_txn(0, 19, 31, 0, -1);
        which = 0;
    endtask

    task automatic test_full_sweep;
        which = 0;
        run_txn(1, 7, 6, 0, 12);
        which = 1;
        run_txn(1, 0, 19, 2, 4);
        which = 0;
    endtask

    task automatic test_random;
        int mode, start, stop;
        for (int t = 0; t < 24; t++) begin
            which = t % 2;
            mode  = int'($urandom_range(0, 1));
            start = int'($urandom_range(0, 31));
            stop  = int'($urandom_range(0, 31));
            run_txn(mode, start, stop, 2, -1);
        end
        which = 0;
    endtask

    task automatic test_mid_reset;
        int cyc;
        which = 0;
        req_mode = 1'b1; req_idx = 5'd0; req_end = 5'd31; sel_ready = 1'b1;
        req_valid_a = 1'b1;
        @(posedge clk); #1;
        req_valid_a = 1'b0;
        cyc = 0;
        while (idx_a !== 5'd3 && cyc < 10) begin
            @(posedge clk); #1;
            cyc++;
        end
        checks++;
        if (idx_a !== 5'd3 || sel_valid_a !== 1'b1) begin
            errors++;
            $display("[TB] FAIL midreset_reach got idx=%0d valid=%b want 3 1", idx_a, sel_valid_a);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (sel_valid_a !== 1'b0 || onehot_a !== 32'd0 || busy_a !== 1'b0 || sel_last_a !== 1'b0) begin
            errors++;
            $display("[TB] FAIL midreset_clear got valid=%b onehot=%h busy=%b last=%b want 0",
                     sel_valid_a, onehot_a, busy_a, sel_last_a);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (sel_valid_a !== 1'b0 || busy_a !== 1'b0 || req_ready_a !== 1'b1) begin
            errors++;
            $display("[TB] FAIL midreset_noresume got valid=%b busy=%b req_ready=%b want 0 0 1",
                     sel_valid_a, busy_a, req_ready_a);
        end
    endtask

`ifdef SET_SEL_SWEEPER_ABORT_EN
    task automatic test_abort;
        int cyc;
        which = 0;
        req_mode = 1'b1; req_idx = 5'd0; req_end = 5'd31; sel_ready = 1'b1;
        req_valid_a = 1'b1;
        @(posedge clk); #1;
        req_valid_a = 1'b0;
        cyc = 0;
        while (idx_a !== 5'd3 && cyc < 10) begin
            @(posedge clk); #1;
            cyc++;
        end
        abort = 1'b1;
        req_mode = 1'b0; req_idx = 5'd9; req_valid_a = 1'b1;
        #1;
        checks++;
        if (req_ready_a !== 1'b0) begin
            errors++;
            $display("[TB] FAIL abort_blocks_req got req_ready=%b want 0", req_ready_a);
        end
        @(posedge clk); #1;
        abort = 1'b0;
        req_valid_a = 1'b0;
        checks++;
        if (sel_valid_a !== 1'b0 || aborted_a !== 1'b1 || busy_a !== 1'b0 || onehot_a !== 32'd0) begin
            errors++;
            $display("[TB] FAIL abort_effect got valid=%b aborted=%b busy=%b onehot=%h want 0 1 0 0",
                     sel_valid_a, aborted_a, busy_a, onehot_a);
        end
        @(posedge clk); #1;
        checks++;
        if (aborted_a !== 1'b0 || sel_valid_a !== 1'b0) begin
            errors++;
            $display("[TB] FAIL abort_pulse got aborted=%b valid=%b want 0 0", aborted_a, sel_valid_a);
        end
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        checks++;
        if (aborted_a !== 1'b0 || aborted_b !== 1'b0) begin
            errors++;
            $display("[TB] FAIL abort_idle got aborted_a=%b aborted_b=%b want 0 0", aborted_a, aborted_b);
        end
        run_txn(1, 28, 2, 0, -1);
    endtask
`endif

    initial begin
        rst_n = 1'b0;
        req_valid_a = 1'b0;
        req_valid_b = 1'b0;
        req_mode = 1'b0;
        req_idx = '0;
        req_end = '0;
        sel_ready = 1'b0;
`ifdef SET_SEL_SWEEPER_ABORT_EN
        abort = 1'b0;
`endif
        test_reset;
        test_single;
        test_sweep_wrap;
        test_backpressure;
        test_range;
        test_full_sweep;
        test_random;
        test_mid_reset;
`ifdef SET_SEL_SWEEPER_ABORT_EN
        test_abort;
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
